// File: rtl/rnn_host_sequencer.sv
// rnn_host_sequencer: bus master that streams character vectors into the rnn slave, steps it, and fetches the dense result.
// Optional poll watchdog: define RNN_SEQ_TIMEOUT_EN.
module rnn_host_sequencer #(
    parameter int unsigned EMB_BITS       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch_valid,
    output logic        ch_ready,
    input  logic [15:0] ch_data,
    input  logic        ch_last,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_positive,
    output logic        busy,
    output logic        err,
    output logic        mst_read,
    output logic        mst_write,
    output logic [2:0]  mst_addr,
    output logic [31:0] mst_wdata,
    input  logic [31:0] mst_rdata
);
    localparam int unsigned EMB_LEN = 1 << EMB_BITS;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned BUS_W   = 32;
    localparam int unsigned IDX_W   = 8;

    localparam logic [ADDR_W-1:0]   A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0]   A_DATA   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]   A_DENSE  = ADDR_W'(7);
    localparam logic [EMB_BITS-1:0] IDX_LAST = EMB_BITS'(EMB_LEN - 1);

    if (EMB_BITS < 1 || EMB_BITS > IDX_W || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_param_range
        $error("rnn_host_sequencer: EMB_BITS or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [3:0] {
        S_SYNC,
        S_IDLE,
        S_LOAD_IN,
        S_KICK,
        S_WAIT_LOAD,
        S_DENSE,
        S_WAIT_VALID,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t              state, state_d;
    logic [EMB_BITS-1:0] idx, idx_d;
    logic                last_seen, last_d;
    logic                read_d, write_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [BUS_W-1:0]    wdata_d;
    logic                res_valid_d, res_pos_d;
    logic [DATA_W-1:0]   res_data_d;
    logic                busy_d, err_d;
    logic                accept, rd_hit;
    logic                unused_rdata_hi;

    assign ch_ready        = (state == S_IDLE) || (state == S_LOAD_IN);
    assign accept          = ch_valid && ch_ready;
    // A poll succeeds only on a cycle where our read strobe is actually on the bus.
    assign rd_hit          = mst_read && mst_rdata[0];
    assign unused_rdata_hi = ^mst_rdata[BUS_W-1:DATA_W];

`ifdef RNN_SEQ_TIMEOUT_EN
    localparam int unsigned      CNT_W       = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] poll_cnt, poll_cnt_d;
    logic             polling, timeout;

    assign polling = (state == S_SYNC) || (state == S_WAIT_LOAD) || (state == S_WAIT_VALID);
    assign timeout = polling && (poll_cnt == TIMEOUT_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt_d;
        end
    end
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        last_d      = last_seen;
        read_d      = 1'b0;
        write_d     = 1'b0;
        addr_d      = '0;
        wdata_d     = '0;
        res_valid_d = res_valid;
        res_data_d  = res_data;
        res_pos_d   = res_positive;
        err_d       = err;

        unique case (state)
            S_SYNC: begin
                if (rd_hit && mst_addr == A_DATA) begin
                    state_d = S_IDLE;
                end else begin
                    read_d = 1'b1;
                    addr_d = A_DATA;
                end
            end
            S_IDLE, S_LOAD_IN: begin
                if (accept) begin
                    write_d = 1'b1;
                    addr_d  = A_DATA;
                    wdata_d = {8'h00, IDX_W'(idx), ch_data};
                    if (idx == IDX_LAST) begin
                        idx_d   = '0;
                        last_d  = ch_last;
                        state_d = S_KICK;
                    end else begin
                        idx_d   = idx + EMB_BITS'(1);
                        state_d = S_LOAD_IN;
                    end
                end
            end
            S_KICK: begin
                write_d = 1'b1;
                addr_d  = A_CTRL;
                state_d = S_WAIT_LOAD;
            end
            S_WAIT_LOAD: begin
                // The kick write is still on the bus in the first cycle; leave a gap before polling.
                if (rd_hit && mst_addr == A_DATA) begin
                    state_d = last_seen ? S_DENSE : S_IDLE;
                end else if (!mst_write) begin
                    read_d = 1'b1;
                    addr_d = A_DATA;
                end
            end
            S_DENSE: begin
                write_d = 1'b1;
                addr_d  = A_DENSE;
                state_d = S_WAIT_VALID;
            end
            S_WAIT_VALID: begin
                if (rd_hit && mst_addr == A_CTRL) begin
                    read_d  = 1'b1;
                    addr_d  = A_DENSE;
                    state_d = S_FETCH;
                end else if (!mst_write) begin
                    read_d = 1'b1;
                    addr_d = A_CTRL;
                end
            end
            S_FETCH: begin
                res_valid_d = 1'b1;
                res_data_d  = mst_rdata[DATA_W-1:0];
                res_pos_d   = ~mst_rdata[DATA_W-1];
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    last_d      = 1'b0;
                    state_d     = S_SYNC;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

`ifdef RNN_SEQ_TIMEOUT_EN
        if (timeout) begin
            state_d = S_IDLE;
            read_d  = 1'b0;
            write_d = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            idx_d   = '0;
            last_d  = 1'b0;
            err_d   = 1'b1;
        end
        poll_cnt_d = (state_d != state || !polling) ? '0 : poll_cnt + CNT_W'(1);
`else
        err_d = 1'b0;
`endif

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_SYNC;
            idx          <= '0;
            last_seen    <= 1'b0;
            mst_read     <= 1'b0;
            mst_write    <= 1'b0;
            mst_addr     <= '0;
            mst_wdata    <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_positive <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_d;
            idx          <= idx_d;
            last_seen    <= last_d;
            mst_read     <= read_d;
            mst_write    <= write_d;
            mst_addr     <= addr_d;
            mst_wdata    <= wdata_d;
            res_valid    <= res_valid_d;
            res_data     <= res_data_d;
            res_positive <= res_pos_d;
            busy         <= busy_d;
            err          <= err_d;
        end
    end

endmodule

// File: tb/tb_rnn_host_sequencer.sv
// Directed bench for rnn_host_sequencer with a small behavioural model of the rnn slave register port.
module tb_rnn_host_sequencer;
    localparam int unsigned EMB_BITS = 2;
    localparam int unsigned TMO      = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ch_valid = 1'b0;
    logic        ch_ready;
    logic [15:0] ch_data = '0;
    logic        ch_last = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_positive;
    logic        busy;
    logic        err;
    logic        mst_read;
    logic        mst_write;
    logic [2:0]  mst_addr;
    logic [31:0] mst_wdata;
    logic [31:0] mst_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rnn_host_sequencer #(.EMB_BITS(EMB_BITS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data), .ch_last(ch_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_positive(res_positive),
        .busy(busy), .err(err),
        .mst_read(mst_read), .mst_write(mst_write), .mst_addr(mst_addr),
        .mst_wdata(mst_wdata), .mst_rdata(mst_rdata)
    );

    // Slave model: LOAD accepts data; addr 0 write runs a step, addr 7 write runs the dense pass.
    typedef enum int {SL_LOAD, SL_RUN, SL_DENSE, SL_VALID, SL_CLEAR} sl_t;
    sl_t         sl_state;
    int          sl_cnt;
    logic        sl_stuck  = 1'b0;
    logic [31:0] sl_result = '0;
    int          viol      = 0;

    always_comb begin
        case (mst_addr)
            3'd1:    mst_rdata = {31'd0, sl_state == SL_LOAD};
            3'd0:    mst_rdata = {31'd0, sl_state == SL_VALID};
            3'd7:    mst_rdata = sl_result;
            default: mst_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            sl_state <= SL_LOAD;
            sl_cnt   <= 0;
        end else begin
            if ((mst_read && mst_write) || (mst_write && mst_addr == 3'd1 && sl_state != SL_LOAD))
                viol <= viol + 1;
            case (sl_state)
                SL_LOAD: begin
                    if (mst_write && mst_addr == 3'd0) begin
                        sl_state <= SL_RUN;
                        sl_cnt   <= 3;
                    end else if (mst_write && mst_addr == 3'd7) begin
                        sl_state <= SL_DENSE;
                        sl_cnt   <= 3;
                    end
                end
                SL_RUN: if (!sl_stuck) begin
                    if (sl_cnt <= 1) sl_state <= SL_LOAD;
                    else sl_cnt <= sl_cnt - 1;
                end
                SL_DENSE: begin
                    if (sl_cnt <= 1) sl_state <= SL_VALID;
                    else sl_cnt <= sl_cnt - 1;
                end
                SL_VALID: if (mst_read && mst_addr == 3'd7) sl_state <= SL_CLEAR;
                SL_CLEAR: sl_state <= SL_LOAD;
                default:  sl_state <= SL_LOAD;
            endcase
        end
    end

    // Bus log: every write, and reads with repeated polls of the same address collapsed.
    logic [35:0] log_q[$];
    logic [35:0] ent;
    always @(negedge clk) begin
        if (mst_write) begin
            log_q.push_back({1'b1, mst_addr, (mst_addr == 3'd1) ? mst_wdata : 32'd0});
        end else if (mst_read) begin
            ent = {1'b0, mst_addr, 32'd0};
            if (log_q.size() == 0 || log_q[$] != ent) log_q.push_back(ent);
        end
    end

    function automatic logic [35:0] enc(input logic w, input logic [2:0] a, input logic [31:0] d);
        return {w, a, d};
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic last);
        int n = 0;
        ch_valid = 1'b1;
        ch_data  = d;
        ch_last  = last;
        while (!ch_ready && n < 300) begin
            tick();
            n++;
        end
        chk("beat_accept_bound", 36'(n < 300), 36'd1);
        tick();
        ch_valid = 1'b0;
        ch_last  = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ch_ready && n < 100) begin
            tick();
            n++;
        end
        chk("ready_bound", 36'(ch_ready), 36'd1);
    endtask

    task automatic wait_res();
        int n = 0;
        while (!res_valid && n < 500) begin
            tick();
            n++;
        end
        chk("res_valid_bound", 36'(res_valid), 36'd1);
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_cleared", 36'(res_valid), 36'd0);
    endtask

    task automatic check_seq1(input logic [31:0] w[4]);
        logic [35:0] exp_q[9];
        logic [35:0] obs;
        for (int i = 0; i < 4; i++) exp_q[i] = enc(1'b1, 3'd1, w[i]);
        exp_q[4] = enc(1'b1, 3'd0, 32'd0);
        exp_q[5] = enc(1'b0, 3'd1, 32'd0);
        exp_q[6] = enc(1'b1, 3'd7, 32'd0);
        exp_q[7] = enc(1'b0, 3'd0, 32'd0);
        exp_q[8] = enc(1'b0, 3'd7, 32'd0);
        chk("seq_len", 36'(log_q.size()), 36'd9);
        for (int i = 0; i < 9; i++) begin
            obs = (i < log_q.size()) ? log_q[i] : '1;
            chk($sformatf("seq_entry%0d", i), obs, exp_q[i]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hold_data;
        int          bad;
        int          n;
        int          n_w0;
        int          n_w7;
        int          n_w1;
        logic [15:0] d3 [12];

        // Reset values
        rst = 1'b1;
        tick();
        tick();
        chk("reset_strobes", 36'({mst_read, mst_write, mst_addr}), 36'd0);
        chk("reset_wdata", 36'(mst_wdata), 36'd0);
        chk("reset_result", 36'({res_valid, res_positive, res_data}), 36'd0);
        chk("reset_status", 36'({busy, err, ch_ready}), 36'd0);
        rst = 1'b0;
        tick();
        chk("sync_poll", 36'({mst_read, mst_write, mst_addr}), 36'({1'b1, 1'b0, 3'd1}));
        tick();
        chk("ready_after_sync", 36'(ch_ready), 36'd1);
        chk("idle_not_busy", 36'(busy), 36'd0);

        // One character with ch_last, negative result
        log_q.delete();
        sl_result = 32'hFFFF_FE80;
        send_beat(16'h0100, 1'b0);
        chk("beat0_bus", 36'({mst_write, mst_addr, mst_wdata}), 36'({1'b1, 3'd1, 32'h0000_0100}));
        send_beat(16'h0200, 1'b0);
        send_beat(16'hFF00, 1'b0);
        send_beat(16'h0000, 1'b1);
        wait_res();
        chk("res_data_neg", 36'(res_data), 36'hFE80);
        chk("res_pos_neg", 36'(res_positive), 36'd0);
        check_seq1('{32'h0000_0100, 32'h0001_0200, 32'h0002_FF00, 32'h0003_0000});

        // Result held while the consumer stalls
        hold_data = res_data;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!res_valid || res_data !== hold_data || ch_ready || mst_read || mst_write || !busy) bad++;
        end
        chk("hold_stable", 36'(bad), 36'd0);
        release_res();

        // Three characters, only the last one flagged
        wait_ready();
        log_q.delete();
        sl_result = 32'h0000_0000;
        for (int k = 0; k < 12; k++) begin
            d3[k] = 16'h0A00 + 16'(k * 3);
            send_beat(d3[k], (k == 0) || (k == 6) || (k == 11));
        end
        wait_res();
        chk("res_data_zero", 36'(res_data), 36'd0);
        chk("res_pos_zero", 36'(res_positive), 36'd1);
        n_w0 = 0;
        n_w7 = 0;
        n_w1 = 0;
        foreach (log_q[i]) begin
            if (log_q[i][35] && log_q[i][34:32] == 3'd0) n_w0++;
            if (log_q[i][35] && log_q[i][34:32] == 3'd7) n_w7++;
            if (log_q[i][35] && log_q[i][34:32] == 3'd1) begin
                if (n_w1 < 12)
                    chk($sformatf("char3_wdata%0d", n_w1), 36'(log_q[i][31:0]),
                        36'({8'h00, 8'(n_w1 % 4), d3[n_w1]}));
                n_w1++;
            end
        end
        chk("char3_kicks", 36'(n_w0), 36'd3);
        chk("char3_dense", 36'(n_w7), 36'd1);
        chk("char3_beats", 36'(n_w1), 36'd12);
        release_res();

        // Reset during WAIT_VALID, then a clean sequence
        wait_ready();
        sl_result = 32'h0000_1234;
        send_beat(16'h1111, 1'b0);
        send_beat(16'h2222, 1'b0);
        send_beat(16'h3333, 1'b0);
        send_beat(16'h4444, 1'b1);
        n = 0;
        while (!(mst_write && mst_addr == 3'd7) && n < 300) begin
            tick();
            n++;
        end
        chk("dense_write_seen", 36'(mst_write && mst_addr == 3'd7), 36'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("midreset_strobes", 36'({mst_read, mst_write, mst_addr}), 36'd0);
        chk("midreset_status", 36'({busy, res_valid, err, ch_ready}), 36'd0);
        rst = 1'b0;
        tick();
        chk("midreset_sync_poll", 36'({mst_read, mst_write, mst_addr}), 36'({1'b1, 1'b0, 3'd1}));
        wait_ready();
        log_q.delete();
        sl_result = 32'h0000_8000;
        send_beat(16'h7FFF, 1'b0);
        send_beat(16'h8000, 1'b0);
        send_beat(16'h0001, 1'b0);
        send_beat(16'hFFFF, 1'b1);
        wait_res();
        chk("res_data_min", 36'(res_data), 36'h8000);
        chk("res_pos_min", 36'(res_positive), 36'd0);
        check_seq1('{32'h0000_7FFF, 32'h0001_8000, 32'h0002_0001, 32'h0003_FFFF});
        release_res();
        wait_ready();

`ifdef RNN_SEQ_TIMEOUT_EN
        // Slave never returns to LOAD: watchdog fires after TMO poll cycles
        sl_stuck = 1'b1;
        send_beat(16'h0001, 1'b0);
        send_beat(16'h0002, 1'b0);
        send_beat(16'h0003, 1'b0);
        send_beat(16'h0004, 1'b1);
        n = 0;
        while (!err && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_err", 36'(err), 36'd1);
        chk("timeout_latency", 36'(n), 36'd17);
        chk("timeout_busy", 36'(busy), 36'd0);
        tick();
        tick();
        tick();
        chk("timeout_strobes", 36'({mst_read, mst_write}), 36'd0);
        chk("timeout_sticky", 36'(err), 36'd1);
`endif

        chk("slave_protocol", 36'(viol), 36'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
